// File: rtl/reg_writeback_bank.sv
// One-entry write-back buffer feeding an NREG register bank, with two read ports registered one cycle after the address.
// o_wr_ready drops only while a pending entry is frozen by i_hold. `define REG_WRITE_FORWARD_EN forwards the pending entry to the read ports.
module reg_writeback_bank #(
  parameter int WIDTH = 4,
  parameter int NREG  = 4,
  parameter int AW    = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_hold,
  input  logic [AW-1:0]    i_rd_addr_a,
  input  logic [AW-1:0]    i_rd_addr_b,
  output logic [WIDTH-1:0] o_rd_data_a,
  output logic [WIDTH-1:0] o_rd_data_b,
  output logic             o_rd_zero_a,
  output logic             o_pend
);

  typedef struct packed {
    logic             vld;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] dat;
  } pend_t;

  pend_t            r_pend;
  logic [WIDTH-1:0] r_bank [NREG];
  logic [WIDTH-1:0] w_bank_ext [2**AW];
  logic [WIDTH-1:0] w_rd_a, w_rd_b;
  logic [WIDTH-1:0] r_rd_a, r_rd_b;
  logic             r_zero_a;
  logic             w_accept, w_commit;

  assign o_wr_ready = !r_pend.vld || !i_hold;
  assign w_accept   = i_wr_valid && o_wr_ready;
  assign w_commit   = r_pend.vld && !i_hold;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pend <= '0;
    end else if (w_accept) begin
      r_pend <= '{vld: 1'b1, addr: i_wr_addr, dat: i_wr_data};
    end else if (w_commit) begin
      r_pend.vld <= 1'b0;
    end
  end

  // Entries addressed at or beyond NREG match no register and are silently dropped.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) r_bank[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_commit && r_pend.addr == AW'(i)) r_bank[i] <= r_pend.dat;
      end
    end
  end

  // Full 2**AW view of the bank so out-of-range read indices return zero.
  for (genvar g = 0; g < 2**AW; g++) begin : g_ext
    if (g < NREG) begin : g_reg
      assign w_bank_ext[g] = r_bank[g];
    end else begin : g_zero
      assign w_bank_ext[g] = '0;
    end
  end

`ifdef REG_WRITE_FORWARD_EN
  localparam logic [AW:0] L_NREG = (AW+1)'(NREG);
  logic w_pend_in_range;

  // A pending entry outside the bank is never forwarded; it will be dropped at commit.
  assign w_pend_in_range = r_pend.vld && ({1'b0, r_pend.addr} < L_NREG);
  assign w_rd_a = (w_pend_in_range && r_pend.addr == i_rd_addr_a) ? r_pend.dat : w_bank_ext[i_rd_addr_a];
  assign w_rd_b = (w_pend_in_range && r_pend.addr == i_rd_addr_b) ? r_pend.dat : w_bank_ext[i_rd_addr_b];
`else
  assign w_rd_a = w_bank_ext[i_rd_addr_a];
  assign w_rd_b = w_bank_ext[i_rd_addr_b];
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_a   <= '0;
      r_rd_b   <= '0;
      r_zero_a <= 1'b1;
    end else begin
      r_rd_a   <= w_rd_a;
      r_rd_b   <= w_rd_b;
      r_zero_a <= (w_rd_a == '0);
    end
  end

  assign o_rd_data_a = r_rd_a;
  assign o_rd_data_b = r_rd_b;
  assign o_rd_zero_a = r_zero_a;
  assign o_pend      = r_pend.vld;

endmodule

// File: tb/tb_reg_writeback_bank.sv
// Directed bench for reg_writeback_bank; AW=3 so that index 4 is reachable with NREG=4.
module tb_reg_writeback_bank;
  localparam int WIDTH = 4;
  localparam int NREG  = 4;
  localparam int AW    = 3;
`ifdef REG_WRITE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             hold = 1'b0;
  logic [AW-1:0]    rd_addr_a = '0;
  logic [AW-1:0]    rd_addr_b = '0;
  logic [WIDTH-1:0] rd_data_a, rd_data_b;
  logic             rd_zero_a, pend;

  int vectors = 0;
  int miscompares = 0;

  reg_writeback_bank #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_hold(hold), .i_rd_addr_a(rd_addr_a), .i_rd_addr_b(rd_addr_b),
    .o_rd_data_a(rd_data_a), .o_rd_data_b(rd_data_b), .o_rd_zero_a(rd_zero_a), .o_pend(pend)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; hold = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    tick(); tick();
    vectors++; if (pend !== 1'b0) begin miscompares++; $display("FAIL reset_pend got %b want 0", pend); end
    vectors++; if (rd_zero_a !== 1'b1) begin miscompares++; $display("FAIL reset_zero got %b want 1", rd_zero_a); end
    rst = 1'b0;
    #1;
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", wr_ready); end
    for (int i = 0; i < NREG; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(NREG - 1 - i);
      tick();
      vectors++; if (rd_data_a !== 4'h0) begin miscompares++; $display("FAIL reset_rd_a r%0d got %h want 0", i, rd_data_a); end
      vectors++; if (rd_data_b !== 4'h0) begin miscompares++; $display("FAIL reset_rd_b r%0d got %h want 0", NREG - 1 - i, rd_data_b); end
      vectors++; if (rd_zero_a !== 1'b1) begin miscompares++; $display("FAIL reset_zero_a r%0d got %b want 1", i, rd_zero_a); end
    end
  endtask

  task automatic test_write_read();
    logic [WIDTH-1:0] exp_first;
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 4'hA;
    tick();
    wr_valid = 1'b0;
    vectors++; if (pend !== 1'b1) begin miscompares++; $display("FAIL wr_pend got %b want 1", pend); end
    rd_addr_a = 3'd2; rd_addr_b = 3'd2;
    tick();
    exp_first = FWD ? 4'hA : 4'h0;
    vectors++; if (rd_data_a !== exp_first) begin miscompares++; $display("FAIL wr_first_a got %h want %h", rd_data_a, exp_first); end
    vectors++; if (rd_data_b !== exp_first) begin miscompares++; $display("FAIL wr_first_b got %h want %h", rd_data_b, exp_first); end
    vectors++; if (rd_zero_a !== !FWD) begin miscompares++; $display("FAIL wr_first_zero got %b want %b", rd_zero_a, !FWD); end
    vectors++; if (pend !== 1'b0) begin miscompares++; $display("FAIL wr_pend_clear got %b want 0", pend); end
    tick();
    vectors++; if (rd_data_a !== 4'hA) begin miscompares++; $display("FAIL wr_second_a got %h want a", rd_data_a); end
    vectors++; if (rd_zero_a !== 1'b0) begin miscompares++; $display("FAIL wr_second_zero got %b want 0", rd_zero_a); end
  endtask

  logic [AW-1:0]    b2b_addr [3] = '{3'd1, 3'd1, 3'd3};
  logic [WIDTH-1:0] b2b_data [3] = '{4'h3, 4'h5, 4'hF};

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = b2b_addr[i]; wr_data = b2b_data[i];
      #1;
      vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready #%0d got %b want 1", i, wr_ready); end
      tick();
    end
    wr_valid = 1'b0;
    vectors++; if (pend !== 1'b1) begin miscompares++; $display("FAIL b2b_pend got %b want 1", pend); end
    tick();
    vectors++; if (pend !== 1'b0) begin miscompares++; $display("FAIL b2b_pend_clear got %b want 0", pend); end
    rd_addr_a = 3'd1; rd_addr_b = 3'd3;
    tick();
    vectors++; if (rd_data_a !== 4'h5) begin miscompares++; $display("FAIL b2b_r1 got %h want 5", rd_data_a); end
    vectors++; if (rd_data_b !== 4'hF) begin miscompares++; $display("FAIL b2b_r3 got %h want f", rd_data_b); end
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] exp_r0;
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'h7; hold = 1'b0;
    tick();
    hold = 1'b1; wr_addr = 3'd1; wr_data = 4'h9;
    rd_addr_a = 3'd0; rd_addr_b = 3'd1;
    exp_r0 = FWD ? 4'h7 : 4'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL hold_ready c%0d got %b want 0", c, wr_ready); end
      tick();
      vectors++; if (rd_data_a !== exp_r0) begin miscompares++; $display("FAIL hold_r0 c%0d got %h want %h", c, rd_data_a, exp_r0); end
      vectors++; if (rd_data_b !== 4'h5) begin miscompares++; $display("FAIL hold_r1 c%0d got %h want 5", c, rd_data_b); end
      vectors++; if (pend !== 1'b1) begin miscompares++; $display("FAIL hold_pend c%0d got %b want 1", c, pend); end
    end
    hold = 1'b0;
    #1;
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL hold_release_ready got %b want 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    vectors++; if (pend !== 1'b1) begin miscompares++; $display("FAIL hold_second_pend got %b want 1", pend); end
    tick();
    vectors++; if (pend !== 1'b0) begin miscompares++; $display("FAIL hold_pend_clear got %b want 0", pend); end
    tick();
    vectors++; if (rd_data_a !== 4'h7) begin miscompares++; $display("FAIL hold_final_r0 got %h want 7", rd_data_a); end
    vectors++; if (rd_data_b !== 4'h9) begin miscompares++; $display("FAIL hold_final_r1 got %h want 9", rd_data_b); end
  endtask

  task automatic test_reset_pending();
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 4'hC;
    tick();
    wr_valid = 1'b0;
    vectors++; if (pend !== 1'b1) begin miscompares++; $display("FAIL rstp_pend got %b want 1", pend); end
    rst = 1'b1;
    #2;
    vectors++; if (pend !== 1'b0) begin miscompares++; $display("FAIL rstp_async_pend got %b want 0", pend); end
    vectors++; if (rd_data_b !== 4'h0) begin miscompares++; $display("FAIL rstp_async_rd_b got %h want 0", rd_data_b); end
    rst = 1'b0;
    rd_addr_a = 3'd3; rd_addr_b = 3'd0;
    tick();
    vectors++; if (rd_data_a !== 4'h0) begin miscompares++; $display("FAIL rstp_r3 got %h want 0", rd_data_a); end
    vectors++; if (rd_data_b !== 4'h0) begin miscompares++; $display("FAIL rstp_r0 got %h want 0", rd_data_b); end
    tick();
    vectors++; if (pend !== 1'b0) begin miscompares++; $display("FAIL rstp_no_commit got %b want 0", pend); end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < NREG; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = WIDTH'(i + 1);
      tick();
    end
    wr_addr = 3'd4; wr_data = 4'hF;
    tick();
    wr_valid = 1'b0;
    vectors++; if (pend !== 1'b1) begin miscompares++; $display("FAIL oor_accept got %b want 1", pend); end
    tick();
    for (int i = 0; i < NREG; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(i);
      tick();
      vectors++; if (rd_data_a !== WIDTH'(i + 1)) begin miscompares++; $display("FAIL oor_rd_a r%0d got %h want %h", i, rd_data_a, WIDTH'(i + 1)); end
      vectors++; if (rd_data_b !== WIDTH'(i + 1)) begin miscompares++; $display("FAIL oor_rd_b r%0d got %h want %h", i, rd_data_b, WIDTH'(i + 1)); end
    end
    rd_addr_a = 3'd4; rd_addr_b = 3'd7;
    tick();
    vectors++; if (rd_data_a !== 4'h0) begin miscompares++; $display("FAIL oor_rd_idx4 got %h want 0", rd_data_a); end
    vectors++; if (rd_zero_a !== 1'b1) begin miscompares++; $display("FAIL oor_zero_idx4 got %b want 1", rd_zero_a); end
    vectors++; if (rd_data_b !== 4'h0) begin miscompares++; $display("FAIL oor_rd_idx7 got %h want 0", rd_data_b); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_hold();
    test_reset_pending();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
